// File: rtl/cordic_vectoring_16.sv
// Iterative 16-bit CORDIC engine, vectoring mode.
// Converts a Cartesian pair (x, y) into an uncompensated magnitude (gain K~1.6468)
// and a binary-angle phase (32768 = pi), one micro-rotation per clock.
module cordic_vectoring_16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] x_in,
    input  logic [15:0] y_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [17:0] mag_out,
    output logic [15:0] angle_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic signed [17:0] x_q;
    logic signed [17:0] y_q;
    logic        [15:0] z_q;
    logic        [3:0]  i_q;

    logic signed [17:0] x_ext_s;
    logic signed [17:0] y_ext_s;
    logic signed [17:0] x_pre_s;
    logic signed [17:0] y_pre_s;
    logic        [15:0] z_pre_s;

    logic signed [17:0] x_sh_s;
    logic signed [17:0] y_sh_s;
    logic signed [17:0] x_d;
    logic signed [17:0] y_d;
    logic        [15:0] z_d;

    // arctan(2^-i) in binary-angle units
    function automatic logic [15:0] atan_lut(input logic [3:0] idx);
        logic [15:0] a;
        case (idx)
            4'd0:    a = 16'd8192;
            4'd1:    a = 16'd4836;
            4'd2:    a = 16'd2555;
            4'd3:    a = 16'd1297;
            4'd4:    a = 16'd651;
            4'd5:    a = 16'd326;
            4'd6:    a = 16'd163;
            4'd7:    a = 16'd81;
            4'd8:    a = 16'd41;
            4'd9:    a = 16'd20;
            4'd10:   a = 16'd10;
            4'd11:   a = 16'd5;
            4'd12:   a = 16'd3;
            4'd13:   a = 16'd1;
            4'd14:   a = 16'd1;
            default: a = 16'd0;
        endcase
        return a;
    endfunction

    // Sign-extend before negation so that -(-32768) is representable.
    assign x_ext_s = {{2{x_in[15]}}, x_in};
    assign y_ext_s = {{2{y_in[15]}}, y_in};

    // Pre-rotation into the right half-plane so the iterations converge.
    always_comb begin
        x_pre_s = x_ext_s;
        y_pre_s = y_ext_s;
        z_pre_s = 16'd0;
        if (!x_in[15]) begin
            x_pre_s = x_ext_s;
            y_pre_s = y_ext_s;
            z_pre_s = 16'd0;
        end else if (!y_in[15]) begin
            x_pre_s = y_ext_s;
            y_pre_s = 18'sd0 - x_ext_s;
            z_pre_s = 16'd16384;
        end else begin
            x_pre_s = 18'sd0 - y_ext_s;
            y_pre_s = x_ext_s;
            z_pre_s = 16'hC000;
        end
    end

    assign x_sh_s = x_q >>> i_q;
    assign y_sh_s = y_q >>> i_q;

    // One micro-rotation driving y toward zero, using pre-edge x and y.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        z_d = z_q;
        if (!y_q[17]) begin
            x_d = x_q + y_sh_s;
            y_d = y_q - x_sh_s;
            z_d = z_q + atan_lut(i_q);
        end else begin
            x_d = x_q - y_sh_s;
            y_d = y_q + x_sh_s;
            z_d = z_q - atan_lut(i_q);
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            mag_out   <= 18'd0;
            angle_out <= 16'd0;
            x_q       <= 18'sd0;
            y_q       <= 18'sd0;
            z_q       <= 16'd0;
            i_q       <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        x_q      <= x_pre_s;
                        y_q      <= y_pre_s;
                        z_q      <= z_pre_s;
                        i_q      <= 4'd0;
                        in_ready <= 1'b0;
                        state_q  <= ROT;
                    end
                end
                ROT: begin
                    x_q <= x_d;
                    y_q <= y_d;
                    z_q <= z_d;
                    if (i_q == 4'd15) begin
                        mag_out   <= $unsigned(x_d);
                        angle_out <= z_d;
                        out_valid <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        i_q <= i_q + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

endmodule
